// File: rtl/bus_phase_sequencer_if.sv
// CPU-side request/response and external bus signals for bus_phase_sequencer.
// The sequencer uses the slave modport; the CPU/bus model uses master.
interface bus_phase_sequencer_if;
    logic        enable;
    logic        req_valid;
    logic        req_write;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        req_ready;
    logic        cpu_ce;
    logic        m2;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_we_n;
    logic        bus_oe_n;
    logic [7:0]  bus_rdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;

    modport slave (
        input  enable, req_valid, req_write, req_addr, req_wdata, bus_rdata,
        output req_ready, cpu_ce, m2, bus_addr, bus_wdata,
        output bus_we_n, bus_oe_n, rsp_valid, rsp_rdata
    );

    modport master (
        output enable, req_valid, req_write, req_addr, req_wdata, bus_rdata,
        input  req_ready, cpu_ce, m2, bus_addr, bus_wdata,
        input  bus_we_n, bus_oe_n, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/bus_phase_sequencer.sv
// Counts master clocks to produce CPU cycle enable, M2 and bus strobes,
// carrying one CPU bus transaction per CPU cycle.
module bus_phase_sequencer #(
    parameter int CYCLE_LEN = 12,
    parameter int M2_RISE   = 5,
    parameter int WR_DELAY  = 2,
    parameter int WR_LEN    = 4
) (
    input logic clk,
    input logic reset,
    bus_phase_sequencer_if.slave bus
);
    localparam int CW = $clog2(CYCLE_LEN);
    localparam logic [CW-1:0] LAST   = CW'(CYCLE_LEN - 1);
    localparam logic [CW-1:0] M2_AT  = CW'(M2_RISE);
    localparam logic [CW-1:0] WR_ON  = CW'(M2_RISE + WR_DELAY);
    localparam logic [CW-1:0] WR_OFF = CW'(M2_RISE + WR_DELAY + WR_LEN - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    if (CYCLE_LEN < 4 || M2_RISE + WR_DELAY + WR_LEN > CYCLE_LEN - 1) begin : g_bad_params
        $error("bus_phase_sequencer: illegal phase parameters");
    end

    logic [0:0]    state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          txn_active, txn_active_nx;
    logic          txn_write, txn_write_nx;
    logic          wrap, accept, rd_done, run_nx;

    assign wrap    = (state == RUN) && (cnt == LAST);
    assign accept  = bus.req_ready && bus.req_valid;
    assign rd_done = wrap && txn_active && !txn_write;
    assign run_nx  = (state_nx == RUN);

    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        txn_active_nx = txn_active;
        txn_write_nx  = txn_write;
        if (state == IDLE) begin
            if (bus.enable) begin
                state_nx = RUN;
                cnt_nx   = '0;
            end
        end else if (wrap) begin
            cnt_nx        = '0;
            txn_active_nx = 1'b0;
            if (!bus.enable) state_nx = IDLE;
        end else begin
            cnt_nx = cnt + 1'b1;
            if (accept) begin
                txn_active_nx = 1'b1;
                txn_write_nx  = bus.req_write;
            end
        end
    end

    // Outputs are computed from the next counter value so they line up
    // with cnt on the clock they are visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            txn_active    <= 1'b0;
            txn_write     <= 1'b0;
            bus.cpu_ce    <= 1'b0;
            bus.req_ready <= 1'b0;
            bus.m2        <= 1'b0;
            bus.bus_we_n  <= 1'b1;
            bus.bus_oe_n  <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            txn_active    <= txn_active_nx;
            txn_write     <= txn_write_nx;
            bus.cpu_ce    <= run_nx && (cnt_nx == '0);
            bus.req_ready <= run_nx && (cnt_nx == '0);
            bus.m2        <= run_nx && (cnt_nx >= M2_AT);
            bus.bus_we_n  <= !(run_nx && txn_active_nx && txn_write_nx &&
                               (cnt_nx >= WR_ON) && (cnt_nx <= WR_OFF));
            bus.bus_oe_n  <= !(run_nx && txn_active_nx && !txn_write_nx &&
                               (cnt_nx >= M2_AT));
            bus.rsp_valid <= rd_done;
            if (rd_done) begin
                bus.rsp_rdata <= bus.bus_rdata;
            end else if (state == IDLE) begin
                bus.rsp_rdata <= '0;
            end
            if (accept) begin
                bus.bus_addr  <= bus.req_addr;
                bus.bus_wdata <= bus.req_wdata;
            end else if (state_nx == IDLE) begin
                bus.bus_addr  <= '0;
                bus.bus_wdata <= '0;
            end
        end
    end
endmodule
